// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register; a flushed, invalid or stalled ID slot loads a zero bubble.
// Define LOAD_USE_STALL_EN to add load-use hazard detection, stall_o and the saturating stall counter.
module id_ex_stage (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [22:0] id_ctrl_i,
   input  logic        id_extsel_i,
   input  logic [31:0] id_instr_i,
   input  logic [31:0] id_pc4_i,
   input  logic [31:0] id_rs_data_i,
   input  logic [31:0] id_rt_data_i,
   input  logic        id_valid_i,
   input  logic        flush_i,
   output logic [22:0] ex_ctrl_o,
   output logic [31:0] ex_pc4_o,
   output logic [31:0] ex_rs_data_o,
   output logic [31:0] ex_rt_data_o,
   output logic [31:0] ex_imm_o,
   output logic [4:0]  ex_shamt_o,
   output logic [4:0]  ex_rs_o,
   output logic [4:0]  ex_rt_o,
   output logic [4:0]  ex_wreg_o,
   output logic        ex_valid_o,
   output logic        stall_o,
   output logic [15:0] stall_cnt_o
);
   logic [22:0] ctrl_d, ctrl_q;
   logic [31:0] pc4_d, pc4_q, rs_data_d, rs_data_q, rt_data_d, rt_data_q, imm_d, imm_q;
   logic [4:0]  shamt_d, shamt_q, rs_d, rs_q, rt_d, rt_q, wreg_d, wreg_q;
   logic        valid_d, valid_q, load;
   logic        unused_opcode;
   assign unused_opcode = ^id_instr_i[31:26];
   assign load = id_valid_i & ~flush_i & ~stall_o;
   always_comb begin
      ctrl_d    = load ? id_ctrl_i : '0;
      pc4_d     = load ? id_pc4_i : '0;
      rs_data_d = load ? id_rs_data_i : '0;
      rt_data_d = load ? id_rt_data_i : '0;
      imm_d     = load ? {{16{id_instr_i[15] & id_extsel_i}}, id_instr_i[15:0]} : '0;
      shamt_d   = load ? id_instr_i[10:6] : '0;
      rs_d      = load ? id_instr_i[25:21] : '0;
      rt_d      = load ? id_instr_i[20:16] : '0;
      // link (connect without RegDst) writes $ra; otherwise rd for R-type, rt for I-type
      wreg_d    = !load ? '0 : (id_ctrl_i[14] & ~id_ctrl_i[19]) ? 5'd31 :
                  id_ctrl_i[19] ? id_instr_i[15:11] : id_instr_i[20:16];
      valid_d   = load;
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ctrl_q    <= '0;
         pc4_q     <= '0;
         rs_data_q <= '0;
         rt_data_q <= '0;
         imm_q     <= '0;
         shamt_q   <= '0;
         rs_q      <= '0;
         rt_q      <= '0;
         wreg_q    <= '0;
         valid_q   <= 1'b0;
      end else begin
         ctrl_q    <= ctrl_d;
         pc4_q     <= pc4_d;
         rs_data_q <= rs_data_d;
         rt_data_q <= rt_data_d;
         imm_q     <= imm_d;
         shamt_q   <= shamt_d;
         rs_q      <= rs_d;
         rt_q      <= rt_d;
         wreg_q    <= wreg_d;
         valid_q   <= valid_d;
      end
   end
   assign ex_ctrl_o    = ctrl_q;
   assign ex_pc4_o     = pc4_q;
   assign ex_rs_data_o = rs_data_q;
   assign ex_rt_data_o = rt_data_q;
   assign ex_imm_o     = imm_q;
   assign ex_shamt_o   = shamt_q;
   assign ex_rs_o      = rs_q;
   assign ex_rt_o      = rt_q;
   assign ex_wreg_o    = wreg_q;
   assign ex_valid_o   = valid_q;
`ifdef LOAD_USE_STALL_EN
   logic [15:0] stall_cnt_d, stall_cnt_q;
   logic        hazard;
   // the bubble inserted by a stall has MemRead=0, so the stall cannot repeat for the same pair
   assign hazard = valid_q & ctrl_q[4] & (wreg_q != 5'd0) & id_valid_i &
                   ((wreg_q == id_instr_i[25:21]) | (wreg_q == id_instr_i[20:16]));
   assign stall_o     = hazard & ~flush_i;
   assign stall_cnt_d = (stall_o & ~&stall_cnt_q) ? stall_cnt_q + 16'd1 : stall_cnt_q;
   always_ff @(posedge clk) begin
      stall_cnt_q <= !rst_n ? '0 : stall_cnt_d;
   end
   assign stall_cnt_o = stall_cnt_q;
`else
   assign stall_o     = 1'b0;
   assign stall_cnt_o = '0;
`endif
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: random and directed stimulus against a spec-level model of the ID/EX register.
module tb_id_ex_stage;
   typedef struct packed {
      logic [22:0] ctrl;
      logic [31:0] pc4, rsd, rtd, imm;
      logic [4:0]  shamt, rs, rt, wreg;
      logic        valid;
   } ex_t;
`ifdef LOAD_USE_STALL_EN
   localparam logic STALL_EN = 1'b1;
`else
   localparam logic STALL_EN = 1'b0;
`endif
   localparam logic [22:0] C_LW   = 23'h008015;
   localparam logic [22:0] C_ADD  = 23'h0A0004;
   localparam logic [22:0] C_JAL  = 23'h004044;
   localparam logic [22:0] C_JALR = 23'h084004;
   localparam logic [22:0] C_IMM  = 23'h008004;
   localparam logic [31:0] I_LW   = {6'h23, 5'd9, 5'd8, 16'h0000};
   localparam logic [31:0] I_ADD  = {6'h00, 5'd8, 5'd11, 5'd10, 5'd0, 6'h20};
   localparam logic [31:0] I_LW0  = {6'h23, 5'd1, 5'd0, 16'h0004};
   localparam logic [31:0] I_ADD0 = {6'h00, 5'd0, 5'd3, 5'd2, 5'd0, 6'h20};
   localparam logic [31:0] I_JALR = {6'h00, 5'd6, 5'd0, 5'd5, 5'd0, 6'h09};
   localparam logic [31:0] I_ORI  = {6'h0d, 5'd1, 5'd2, 16'h8001};
   localparam logic [31:0] I_ADDI = {6'h08, 5'd1, 5'd2, 16'h8001};

   logic clk = 1'b0, rst_n = 1'b0;
   logic [22:0] id_ctrl = '0;
   logic [31:0] id_instr = '0, id_pc4 = '0, id_rs_data = '0, id_rt_data = '0;
   logic id_extsel = 1'b0, id_valid = 1'b0, flush = 1'b0;
   logic [22:0] ex_ctrl_o;
   logic [31:0] ex_pc4_o, ex_rs_data_o, ex_rt_data_o, ex_imm_o;
   logic [4:0]  ex_shamt_o, ex_rs_o, ex_rt_o, ex_wreg_o;
   logic ex_valid_o, stall_o;
   logic [15:0] stall_cnt_o;
   int checks = 0, errors = 0;
   ex_t m = '0;
   logic [15:0] m_cnt = '0;
   logic [15:0] cnt0;

   always #5 clk = ~clk;

   id_ex_stage dut (
      .clk(clk), .rst_n(rst_n), .id_ctrl_i(id_ctrl), .id_extsel_i(id_extsel), .id_instr_i(id_instr),
      .id_pc4_i(id_pc4), .id_rs_data_i(id_rs_data), .id_rt_data_i(id_rt_data), .id_valid_i(id_valid),
      .flush_i(flush), .ex_ctrl_o(ex_ctrl_o), .ex_pc4_o(ex_pc4_o), .ex_rs_data_o(ex_rs_data_o),
      .ex_rt_data_o(ex_rt_data_o), .ex_imm_o(ex_imm_o), .ex_shamt_o(ex_shamt_o), .ex_rs_o(ex_rs_o),
      .ex_rt_o(ex_rt_o), .ex_wreg_o(ex_wreg_o), .ex_valid_o(ex_valid_o), .stall_o(stall_o),
      .stall_cnt_o(stall_cnt_o)
   );

   wire [187:0] obs  = {ex_ctrl_o, ex_pc4_o, ex_rs_data_o, ex_rt_data_o, ex_imm_o, ex_shamt_o,
                        ex_rs_o, ex_rt_o, ex_wreg_o, ex_valid_o, stall_cnt_o};
   wire [187:0] expv = {m, m_cnt};

   function automatic logic model_stall();
`ifdef LOAD_USE_STALL_EN
      return m.valid && m.ctrl[4] && m.wreg != 5'd0 && id_valid && !flush &&
             (m.wreg == id_instr[25:21] || m.wreg == id_instr[20:16]);
`else
      return 1'b0;
`endif
   endfunction

   task automatic drive(input logic [22:0] c, input logic [31:0] ins, input logic ext, input logic v, input logic f);
      id_ctrl = c; id_instr = ins; id_extsel = ext; id_valid = v; flush = f;
      id_pc4 = $urandom; id_rs_data = $urandom; id_rt_data = $urandom;
      #1;
   endtask

   task automatic tick();
      logic st;
      logic bub;
      st  = model_stall();
      bub = st || flush || !id_valid;
      @(posedge clk);
      if (!rst_n) begin
         m = '0; m_cnt = '0;
      end else begin
         if (st && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
         if (bub) m = '0;
         else begin
            m.ctrl = id_ctrl; m.pc4 = id_pc4; m.rsd = id_rs_data; m.rtd = id_rt_data;
            m.imm = id_extsel ? 32'($signed(id_instr[15:0])) : 32'(id_instr[15:0]);
            m.shamt = id_instr[10:6]; m.rs = id_instr[25:21]; m.rt = id_instr[20:16];
            m.wreg = (id_ctrl[14] && !id_ctrl[19]) ? 5'd31 : id_ctrl[19] ? id_instr[15:11] : id_instr[20:16];
            m.valid = 1'b1;
         end
      end
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      drive(23'($urandom), $urandom, 1'b1, 1'b1, 1'b0);
      tick();
      checks++; if (obs !== '0) begin errors++; $display("FAIL reset_outputs got=%h exp=0", obs); end
      rst_n = 1'b1;
      drive(C_ADD, I_ADD, 1'b0, 1'b1, 1'b0);
      checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL reset_release_stall got=%b exp=0", stall_o); end
      tick();
      checks++; if (obs !== expv) begin errors++; $display("FAIL reset_first_load got=%h exp=%h", obs, expv); end
   endtask

   task automatic test_load_use();
      drive(C_LW, I_LW, 1'b1, 1'b1, 1'b0);
      tick();
      checks++; if (ex_wreg_o !== 5'd8) begin errors++; $display("FAIL lu_lw_wreg got=%0d exp=8", ex_wreg_o); end
      cnt0 = m_cnt;
      drive(C_ADD, I_ADD, 1'b0, 1'b1, 1'b0);
      checks++; if (stall_o !== STALL_EN) begin errors++; $display("FAIL lu_stall got=%b exp=%b", stall_o, STALL_EN); end
      tick();
      checks++; if (ex_ctrl_o !== (STALL_EN ? 23'h0 : C_ADD)) begin errors++; $display("FAIL lu_bubble_ctrl got=%h", ex_ctrl_o); end
      checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL lu_stall_one_cycle got=%b exp=0", stall_o); end
      tick();
      checks++; if (ex_ctrl_o !== C_ADD || ex_wreg_o !== 5'd10 || !ex_valid_o) begin errors++; $display("FAIL lu_add_enters ctrl=%h wreg=%0d", ex_ctrl_o, ex_wreg_o); end
      checks++; if (stall_cnt_o !== cnt0 + 16'(STALL_EN)) begin errors++; $display("FAIL lu_count got=%0d exp=%0d", stall_cnt_o, cnt0 + 16'(STALL_EN)); end
   endtask

   task automatic test_r0();
      drive(C_LW, I_LW0, 1'b1, 1'b1, 1'b0);
      tick();
      drive(C_ADD, I_ADD0, 1'b0, 1'b1, 1'b0);
      checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL r0_stall got=%b exp=0", stall_o); end
      tick();
      checks++; if (ex_ctrl_o !== C_ADD || ex_wreg_o !== 5'd2) begin errors++; $display("FAIL r0_no_bubble ctrl=%h wreg=%0d", ex_ctrl_o, ex_wreg_o); end
   endtask

   task automatic test_flush();
      drive(C_LW, I_LW, 1'b1, 1'b1, 1'b0);
      tick();
      drive(C_ADD, I_ADD, 1'b0, 1'b1, 1'b1);
      checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL flush_stall got=%b exp=0", stall_o); end
      cnt0 = m_cnt;
      tick();
      checks++; if (ex_ctrl_o !== '0 || ex_valid_o !== 1'b0 || ex_wreg_o !== '0) begin errors++; $display("FAIL flush_bubble ctrl=%h valid=%b", ex_ctrl_o, ex_valid_o); end
      checks++; if (stall_cnt_o !== cnt0) begin errors++; $display("FAIL flush_count got=%0d exp=%0d", stall_cnt_o, cnt0); end
   endtask

   task automatic test_wreg_imm();
      drive(C_JAL, 32'h0C000010, 1'b0, 1'b1, 1'b0);
      tick();
      checks++; if (ex_wreg_o !== 5'd31) begin errors++; $display("FAIL jal_wreg got=%0d exp=31", ex_wreg_o); end
      drive(C_JALR, I_JALR, 1'b0, 1'b1, 1'b0);
      tick();
      checks++; if (ex_wreg_o !== 5'd5) begin errors++; $display("FAIL jalr_wreg got=%0d exp=5", ex_wreg_o); end
      drive(C_IMM, I_ORI, 1'b0, 1'b1, 1'b0);
      tick();
      checks++; if (ex_imm_o !== 32'h00008001) begin errors++; $display("FAIL ori_imm got=%h exp=00008001", ex_imm_o); end
      drive(C_IMM, I_ADDI, 1'b1, 1'b1, 1'b0);
      tick();
      checks++; if (ex_imm_o !== 32'hFFFF8001) begin errors++; $display("FAIL addi_imm got=%h exp=ffff8001", ex_imm_o); end
      drive(C_ADD, I_ADD, 1'b0, 1'b0, 1'b0);
      tick();
      checks++; if (ex_ctrl_o !== '0 || ex_valid_o !== 1'b0 || ex_imm_o !== '0) begin errors++; $display("FAIL invalid_bubble ctrl=%h valid=%b", ex_ctrl_o, ex_valid_o); end
   endtask

   task automatic test_random();
      logic [31:0] ins;
      for (int i = 0; i < 400; i++) begin
         ins = $urandom;
         ins[25:21] = 5'($urandom_range(0, 3));
         ins[20:16] = 5'($urandom_range(0, 3));
         drive(23'($urandom), ins, 1'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0);
         checks++; if (stall_o !== model_stall()) begin errors++; $display("FAIL rand_stall i=%0d got=%b exp=%b", i, stall_o, model_stall()); end
         tick();
         checks++; if (obs !== expv) begin errors++; $display("FAIL rand_outputs i=%0d got=%h exp=%h", i, obs, expv); end
      end
   endtask

   task automatic test_reset_mid_stall();
      drive(C_LW, I_LW, 1'b1, 1'b1, 1'b0);
      tick();
      drive(C_ADD, I_ADD, 1'b0, 1'b1, 1'b0);
      checks++; if (stall_o !== STALL_EN) begin errors++; $display("FAIL rms_stall got=%b exp=%b", stall_o, STALL_EN); end
      rst_n = 1'b0;
      tick();
      checks++; if (obs !== '0) begin errors++; $display("FAIL rms_outputs got=%h exp=0", obs); end
      rst_n = 1'b1;
      #1;
      checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL rms_no_replay got=%b exp=0", stall_o); end
      tick();
      checks++; if (ex_ctrl_o !== C_ADD || ex_wreg_o !== 5'd10) begin errors++; $display("FAIL rms_add ctrl=%h wreg=%0d", ex_ctrl_o, ex_wreg_o); end
   endtask

`ifdef LOAD_USE_STALL_EN
   task automatic test_saturate();
      for (int i = 0; i < 65540; i++) begin
         drive(C_LW, I_LW, 1'b1, 1'b1, 1'b0);
         tick();
         drive(C_ADD, I_ADD, 1'b0, 1'b1, 1'b0);
         tick();
      end
      checks++; if (stall_cnt_o !== 16'hFFFF || m_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_count got=%h exp=ffff", stall_cnt_o); end
   endtask
`endif

   initial begin
      test_reset();
      test_load_use();
      test_r0();
      test_flush();
      test_wreg_imm();
      test_random();
      test_reset_mid_stall();
`ifdef LOAD_USE_STALL_EN
      test_saturate();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
